imm_encoder: RTL and testbench
==============================

# imm_encoder

Instruction encoder for the single-cycle RISC-V core's test and boot infrastructure. It is the inverse of the core's immediate decode path. It accepts a request with a format code, opcode, register fields and a 32-bit immediate. It range-checks the immediate, scatters it into the RV32I bit positions and emits the resulting instruction words over a valid/ready stream. A load-immediate (LI) pseudo format expands into a LUI+ADDI pair, so the block needs a small output state machine.

## Interface
Parameters: none.

- clk  input  1  clock; everything samples on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=I, 1=S, 2=B, 3=J, 4=U, 5=LI, 6..7 illegal
- in_opcode  input  7  opcode[6:0]; ignored for LI
- in_rd, in_rs1, in_rs2  input  5 each  register fields
- in_funct3  input  3  funct3 field
- in_imm  input  32  immediate, two's complement byte offset
- out_valid  output  1  instruction word present
- out_ready  input  1  consumer takes word when out_valid && out_ready
- out_instr  output  32  encoded instruction
- out_last  output  1  final word of this request
- out_err  output  1  request was illegal or out of range; out_instr = NOP

## Operation
Request fields are registered at acceptance. The encoding per format is:
- **I:** {imm[11:0], rs1, f3, rd, op}. Legal iff imm[31:11] are all equal.
- **S:** {imm[11:5], rs2, rs1, f3, imm[4:0], op}. Same range rule as I.
- **B:** {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. Legal iff imm[31:12] are all equal and imm[0]=0.
- **J:** {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Legal iff imm[31:20] are all equal and imm[0]=0.
- **U:** {imm[31:12], rd, op}. Legal iff imm[11:0]=0.
- **LI:** always legal.
  - hi = imm[31:12] + imm[11], 20-bit wrap (0xFFFFF+1 → 0).
  - lo = imm[11:0].
  - Word A = LUI {hi, rd, 0110111}.
  - Word B = ADDI {lo, rs1, 000, rd, 0010011}, with rs1 = rd when word A is sent and rs1 = x0 otherwise.
  - hi≠0 and lo≠0: A (last=0), then B (last=1).
  - hi≠0 and lo=0: A only (last=1).
  - hi=0: B only with rs1=x0 (last=1). This covers imm=0.
- **Illegal fmt or range failure:** one word, out_instr=32'h00000013, out_err=1, out_last=1.
- The encoder never inspects in_opcode semantics; the caller supplies a matching opcode.

State machine:
- IDLE: in_ready=1. On accept, load the first word into the output register and go to EMIT_HI (two-word LI) or EMIT_LAST (all other cases).
- EMIT_HI: out_valid=1, out_last=0. On out_ready, load word B and go to EMIT_LAST.
- EMIT_LAST: out_valid=1, out_last=1. On out_ready, go to IDLE.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE.
  - out_valid=0, out_instr=0, out_last=0, out_err=0.
  - in_ready reflects IDLE (1), but nothing is accepted while rst_n=0.
- All outputs are registered except in_ready, which is decoded combinationally as (state==IDLE).
- Latency: accept at edge N → out_valid=1 after edge N, i.e. in cycle N+1.
- For a two-word LI, word B follows one cycle after word A is taken.
- in_ready=0 from the accept edge until the last word is taken. Throughput is at most one request per 2 cycles.
- Backpressure: while out_valid=1 && out_ready=0, out_instr, out_last and out_err hold stable.
- out_valid never drops without a handshake, except on reset.
- A request presented with in_valid in non-IDLE states is ignored and must be held by the producer.
- Reset during EMIT_HI discards word B; the first post-reset accept starts clean.

## Test plan
- **I format:** op=0010011, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF → one word 0xFFF10093, last=1, err=0, out_valid 1 cycle after accept.
- **LI expansion:**
  - imm=0x12345FFF, rd=5 → 0x123462B7 (last=0), then 0xFFF28293 (last=1).
  - imm=0x000007FF, rd=3 → single word 0x7FF00193.
- **J format:** op=1101111, rd=1, imm=0x800 → 0x001000EF.
- **Errors:**
  - B with imm=3 → 0x00000013, err=1.
  - I with imm=2048 → err=1.
  - fmt=7 → err=1.
- **Backpressure:** hold out_ready=0 for 5 cycles on the LI word A → word stable, in_ready=0, word B still delivered afterwards, nothing lost or duplicated.
- **Reset mid-request:** pulse rst_n low after LI word A is taken → out_valid=0 immediately, no word B, next request encodes correctly.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: range-checks an immediate, scatters it into the
// instruction format and streams one or two words (LI -> LUI+ADDI).
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LAST} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_word_b;
    logic        r_valid;
    logic        r_last;
    logic        r_err;

    logic [19:0] w_hi;
    logic [11:0] w_lo;
    logic        w_legal;
    logic        w_two;
    logic        w_err;
    logic [31:0] w_first;
    logic [31:0] w_second;
    logic        w_accept;

    always_comb begin
        w_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
        w_lo     = in_imm[11:0];
        w_legal  = 1'b0;
        w_two    = 1'b0;
        w_first  = NOP;
        w_second = NOP;
        case (in_fmt)
            3'd0: begin
                w_legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
                w_first = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            3'd1: begin
                w_legal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
                w_first = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            3'd2: begin
                w_legal = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
                w_first = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            end
            3'd3: begin
                w_legal = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
                w_first = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            3'd4: begin
                w_legal = ~(|in_imm[11:0]);
                w_first = {in_imm[31:12], in_rd, in_opcode};
            end
            3'd5: begin
                // ADDI sources rd only when the LUI word precedes it
                w_legal = 1'b1;
                if (w_hi != '0) begin
                    w_first  = {w_hi, in_rd, 7'b0110111};
                    w_two    = (w_lo != '0);
                    w_second = {w_lo, in_rd, 3'b000, in_rd, 7'b0010011};
                end else begin
                    w_first  = {w_lo, 5'd0, 3'b000, in_rd, 7'b0010011};
                end
            end
            default: ;
        endcase
        w_err = ~w_legal;
        if (!w_legal) begin
            w_first = NOP;
            w_two   = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_two ? EMIT_HI : EMIT_LAST;
                end
            end
            EMIT_HI:   if (out_ready) w_state_nxt = EMIT_LAST;
            EMIT_LAST: if (out_ready) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_instr  <= '0;
            r_word_b <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_instr  <= w_first;
                r_word_b <= w_second;
                r_last   <= ~w_two;
                r_err    <= w_err;
                r_valid  <= 1'b1;
            end else if (r_state == EMIT_HI && out_ready) begin
                r_instr <= r_word_b;
                r_last  <= 1'b1;
            end else if (r_state == EMIT_LAST && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_last  = r_last;
    assign out_err   = r_err;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a reference model queues expected words at
// request acceptance; an independent monitor pops and compares on each handshake.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } word_t;

    word_t exp_q[$];
    int    n_vec    = 0;
    int    n_err    = 0;
    int    rdy_mode = 0;   // 0 random, 1 stall, 2 always ready

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
    );

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
            n_err++;
        end
    endtask

    function automatic word_t mk(input logic [31:0] w, input logic l, input logic e);
        word_t r;
        r.instr = w;
        r.last  = l;
        r.err   = e;
        return r;
    endfunction

    // Reference: legality from signed ranges, LI split from rounding arithmetic
    function automatic void model_push(input logic [2:0] fmt, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [31:0] imm);
        int          s;
        logic [31:0] rounded;
        logic [19:0] hi;
        logic [11:0] lo;
        word_t       bad;
        s   = $signed(imm);
        bad = mk(32'h0000_0013, 1'b1, 1'b1);
        case (fmt)
            3'd0: if (s >= -2048 && s <= 2047)
                      exp_q.push_back(mk({imm[11:0], rs1, f3, rd, op}, 1'b1, 1'b0));
                  else exp_q.push_back(bad);
            3'd1: if (s >= -2048 && s <= 2047)
                      exp_q.push_back(mk({imm[11:5], rs2, rs1, f3, imm[4:0], op}, 1'b1, 1'b0));
                  else exp_q.push_back(bad);
            3'd2: if (s >= -4096 && s <= 4095 && (s % 2) == 0)
                      exp_q.push_back(mk({imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op},
                                         1'b1, 1'b0));
                  else exp_q.push_back(bad);
            3'd3: if (s >= -(1 << 20) && s < (1 << 20) && (s % 2) == 0)
                      exp_q.push_back(mk({imm[20], imm[10:1], imm[11], imm[19:12], rd, op},
                                         1'b1, 1'b0));
                  else exp_q.push_back(bad);
            3'd4: if ((imm % 4096) == 0)
                      exp_q.push_back(mk({imm[31:12], rd, op}, 1'b1, 1'b0));
                  else exp_q.push_back(bad);
            3'd5: begin
                rounded = imm + 32'h800;
                hi      = rounded[31:12];
                lo      = imm[11:0];
                if (hi == 0) begin
                    exp_q.push_back(mk({lo, 5'd0, 3'b000, rd, 7'b0010011}, 1'b1, 1'b0));
                end else if (lo == 0) begin
                    exp_q.push_back(mk({hi, rd, 7'b0110111}, 1'b1, 1'b0));
                end else begin
                    exp_q.push_back(mk({hi, rd, 7'b0110111}, 1'b0, 1'b0));
                    exp_q.push_back(mk({lo, rd, 3'b000, rd, 7'b0010011}, 1'b1, 1'b0));
                end
            end
            default: exp_q.push_back(bad);
        endcase
    endfunction

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input bit directed, input int nexp,
                        input word_t e0, input word_t e1);
        int k;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
            n_err++;
            in_valid = 1'b0;
        end else begin
            if (directed) begin
                exp_q.push_back(e0);
                if (nexp > 1) exp_q.push_back(e1);
            end else begin
                model_push(fmt, op, rd, rs1, rs2, f3, imm);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_vec++;
            chk({31'd0, out_valid}, 32'd1, "latency_valid");
            chk({31'd0, in_ready}, 32'd0, "busy_in_ready");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) begin
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            n_err++;
        end
    endtask

    task automatic check_reset();
        chk({31'd0, out_valid}, 32'd0, "rst_out_valid");
        chk(out_instr, 32'd0, "rst_out_instr");
        chk({31'd0, out_last}, 32'd0, "rst_out_last");
        chk({31'd0, out_err}, 32'd0, "rst_out_err");
        chk({31'd0, in_ready}, 32'd1, "rst_in_ready");
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 9) < 7);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        word_t got, exp, hold;
        bit    stalled;
        stalled = 1'b0;
        hold    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            got = mk(out_instr, out_last, out_err);
            if (stalled && (!out_valid || got != hold)) begin
                $display("FAIL hold_stable: got v=%b %h/%b/%b, expected v=1 %h/%b/%b",
                         out_valid, got.instr, got.last, got.err, hold.instr, hold.last, hold.err);
                n_err++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_word: got %h, expected no word", out_instr);
                    n_err++;
                end else begin
                    exp = exp_q.pop_front();
                    if (got != exp) begin
                        $display("FAIL word: got %h last=%b err=%b, expected %h last=%b err=%b",
                                 got.instr, got.last, got.err, exp.instr, exp.last, exp.err);
                        n_err++;
                    end
                end
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                hold    = got;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] imm;
        logic [2:0]  fmt;
        rst_n = 1'b0; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;

        send(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1,
             mk(32'hFFF1_0093, 1'b1, 1'b0), '0);
        send(3'd5, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF, 1'b1, 2,
             mk(32'h1234_62B7, 1'b0, 1'b0), mk(32'hFFF2_8293, 1'b1, 1'b0));
        send(3'd5, 7'd0, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0000_07FF, 1'b1, 1,
             mk(32'h7FF0_0193, 1'b1, 1'b0), '0);
        send(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 1'b1, 1,
             mk(32'h0010_00EF, 1'b1, 1'b0), '0);
        send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b1, 1,
             mk(32'h0000_0013, 1'b1, 1'b1), '0);
        send(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048, 1'b1, 1,
             mk(32'h0000_0013, 1'b1, 1'b1), '0);
        send(3'd7, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd0, 1'b1, 1,
             mk(32'h0000_0013, 1'b1, 1'b1), '0);
        drain();

        // Backpressure on LI word A
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(3'd5, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF, 1'b1, 2,
             mk(32'h1234_62B7, 1'b0, 1'b0), mk(32'hFFF2_8293, 1'b1, 1'b0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk(out_instr, 32'h1234_62B7, "bp_instr");
            chk({31'd0, out_valid}, 32'd1, "bp_valid");
            chk({31'd0, in_ready}, 32'd0, "bp_in_ready");
        end
        rdy_mode = 2;
        drain();

        // Reset right after LI word A is taken
        repeat (2) @(posedge clk);
        #1;
        send(3'd5, 7'd0, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0ABC_D123, 1'b1, 2,
             mk(32'h0ABC_D3B7, 1'b0, 1'b0), mk(32'h1233_8393, 1'b1, 1'b0));
        @(posedge clk); #1;
        chk(out_instr, 32'h1233_8393, "mid_word_b");
        rst_n = 1'b0;
        #1;
        chk({31'd0, out_valid}, 32'd0, "mid_rst_valid");
        exp_q.delete();
        @(posedge clk); #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(3'd4, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 32'hDEAD_B000, 1'b1, 1,
             mk(32'hDEAD_B4B7, 1'b1, 1'b0), '0);
        drain();

        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = 32'($urandom_range(0, 32'h40_0000)) - 32'h20_0000;
                3:       imm = $urandom & 32'hFFFF_F000;
                default: case ($urandom_range(0, 5))
                             0:       imm = 32'h0000_0000;
                             1:       imm = 32'hFFFF_F800;
                             2:       imm = 32'h0000_0800;
                             3:       imm = 32'hFFFF_FFFF;
                             4:       imm = 32'h000F_FFFE;
                             default: imm = 32'hFFF0_0000;
                         endcase
            endcase
            fmt = 3'($urandom_range(0, 7));
            send(fmt, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), imm, 1'b0, 0, '0, '0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
